// File: rtl/fp_pkg.sv
// Shared definitions for the fixed-point multiplier / accumulator datapath:
// width helpers and the accumulator FSM state encoding.
package fp_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int int_bits(input int nb, input int nbf);
    return nb - nbf;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default product format shared with the multiplier stage.
  localparam int NB_PROD  = 12;
  localparam int NBF_PROD = 11;
  localparam int NBI_PROD = NB_PROD - NBF_PROD;

endpackage

// File: rtl/fp_acc_round_sat_if.sv
// Product-in / sum-out bundle between the multiplier and the tap-sum accumulator.
interface fp_acc_round_sat_if #(
  parameter int NB_IN  = 12,
  parameter int NB_OUT = 10,
  parameter int NB_ACC = 15
);
  logic                     i_valid;
  logic signed [NB_IN-1:0]  i_data;
  logic                     o_ready;
  logic                     o_valid;
  logic signed [NB_OUT-1:0] o_data;
  logic signed [NB_ACC-1:0] o_acc;
  logic                     o_sat;

  modport master (output i_valid, i_data, input o_ready, o_valid, o_data, o_acc, o_sat);
  modport slave  (input i_valid, i_data, output o_ready, o_valid, o_data, o_acc, o_sat);
endinterface

// File: rtl/fp_round_sat.sv
// Combinational round-half-up, shift and saturate from a wide fixed-point
// value to a narrower output format.
module fp_round_sat #(
  parameter int NB_IN_RS  = 15,
  parameter int NBF_IN_RS = 11,
  parameter int NB_OUT    = 10,
  parameter int NBF_OUT   = 9
) (
  input  logic signed [NB_IN_RS-1:0] acc_in,
  output logic signed [NB_OUT-1:0]   data_out,
  output logic                       sat_out
);
  localparam int SH = NBF_IN_RS - NBF_OUT;
  localparam int RW = NB_IN_RS + 1;
  localparam logic signed [RW-1:0] HALF = RW'(2 ** (SH - 1));

  function automatic logic signed [RW-1:0] round_half_up(input logic signed [NB_IN_RS-1:0] a);
    logic signed [RW-1:0] r;
    r = RW'(a) + HALF;
    return r >>> SH;
  endfunction

  // Returns {sat, data}; the value fits only if every bit above the result
  // sign bit matches it.
  function automatic logic [NB_OUT:0] saturate(input logic signed [RW-1:0] r);
    logic [RW-NB_OUT:0] top;
    top = r[RW-1:NB_OUT-1];
    if ((&top) || !(|top)) return {1'b0, r[NB_OUT-1:0]};
    else if (r[RW-1])      return {1'b1, 1'b1, {(NB_OUT-1){1'b0}}};
    else                   return {1'b1, 1'b0, {(NB_OUT-1){1'b1}}};
  endfunction

  assign {sat_out, data_out} = saturate(round_half_up(acc_in));

endmodule

// File: rtl/fp_acc_round_sat.sv
// Sums N_TERMS signed products at full resolution, then rounds and saturates
// the total into the output format with a one-cycle valid pulse.
module fp_acc_round_sat
  import fp_pkg::*;
#(
  parameter  int NB_IN   = 12,
  parameter  int NBF_IN  = 11,
  parameter  int N_TERMS = 8,
  parameter  int NB_OUT  = 10,
  parameter  int NBF_OUT = 9,
  localparam int NB_ACC  = NB_IN + clog2(N_TERMS)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  fp_acc_round_sat_if.slave  bus
);
  localparam int CW = clog2(N_TERMS) + 1;

  state_t                   state, state_nxt;
  logic signed [NB_ACC-1:0] acc_p0, acc_nxt, sum_p0;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic                     accept, load_out;
  logic signed [NB_OUT-1:0] data_rs, data_p1;
  logic                     sat_rs, sat_p1;
  logic signed [NB_ACC-1:0] acc_p1;

  assign accept = bus.i_valid && bus.o_ready;
  // First sample of a frame starts from zero rather than the stale sum.
  assign sum_p0 = ((state == ACC) ? acc_p0 : NB_ACC'(0)) + NB_ACC'(bus.i_data);

  fp_round_sat #(
    .NB_IN_RS  (NB_ACC),
    .NBF_IN_RS (NBF_IN),
    .NB_OUT    (NB_OUT),
    .NBF_OUT   (NBF_OUT)
  ) u_round_sat (
    .acc_in   (sum_p0),
    .data_out (data_rs),
    .sat_out  (sat_rs)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_p0;
    cnt_nxt   = cnt;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = sum_p0;
          cnt_nxt   = CW'(1);
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_nxt = sum_p0;
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(N_TERMS - 1)) begin
            load_out  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: accumulator and frame control
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      acc_p0 <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      acc_p0 <= acc_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Stage p1: result registers, held until the next frame completes
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      data_p1 <= '0;
      acc_p1  <= '0;
      sat_p1  <= 1'b0;
    end else if (load_out) begin
      data_p1 <= data_rs;
      acc_p1  <= sum_p0;
      sat_p1  <= sat_rs;
    end
  end

  assign bus.o_ready = (state != DONE);
  assign bus.o_valid = (state == DONE);
  assign bus.o_data  = data_p1;
  assign bus.o_acc   = acc_p1;
  assign bus.o_sat   = sat_p1;

endmodule

// File: tb/tb_fp_acc_round_sat.sv
// Bench for fp_acc_round_sat: fixed vector table, reset/back-to-back
// sequences, and random frames against a real-arithmetic reference.
module tb_fp_acc_round_sat;
  localparam int NB_IN   = 12;
  localparam int NBF_IN  = 11;
  localparam int N       = 8;
  localparam int NB_OUT  = 10;
  localparam int NBF_OUT = 9;
  localparam int NB_ACC  = 15;

  typedef struct packed {
    logic [N-1:0][NB_IN-1:0] smp;
    int                      gap;
    logic                    hold;
    int                      exp_acc;
    int                      exp_data;
    logic                    exp_sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_acc_round_sat_if #(.NB_IN(NB_IN), .NB_OUT(NB_OUT), .NB_ACC(NB_ACC)) bus ();

  fp_acc_round_sat #(
    .NB_IN(NB_IN), .NBF_IN(NBF_IN), .N_TERMS(N), .NB_OUT(NB_OUT), .NBF_OUT(NBF_OUT)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int pulses[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.o_valid === 1'b1) pulses.push_back(cyc);
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int first, input int rest, input int gap, input logic hold,
                               input int ea, input int ed, input logic es);
    vec_t v;
    for (int i = 0; i < N; i++) v.smp[i] = NB_IN'((i == 0) ? first : rest);
    v.gap = gap; v.hold = hold; v.exp_acc = ea; v.exp_data = ed; v.exp_sat = es;
    return v;
  endfunction

  // Reference: exact sum, then round half toward +inf in real arithmetic and clip.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   s, q, hi, lo;
    real  scale;
    r     = v;
    s     = 0;
    for (int i = 0; i < N; i++) s += int'($signed(v.smp[i]));
    scale = 2.0 ** (NBF_IN - NBF_OUT);
    q     = $rtoi($floor(real'(s) / scale + 0.5));
    hi    = 2 ** (NB_OUT - 1) - 1;
    lo    = -(2 ** (NB_OUT - 1));
    r.exp_acc  = s;
    r.exp_sat  = (q > hi) || (q < lo);
    r.exp_data = (q > hi) ? hi : (q < lo) ? lo : q;
    return r;
  endfunction

  task automatic run_frame(input vec_t v, input logic settle, input string tag);
    int g, k;
    for (int i = 0; i < N; i++) begin
      g = $urandom_range(v.gap);
      if (g > 0) begin
        bus.i_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      bus.i_valid = 1'b1;
      bus.i_data  = v.smp[i];
      k = 0;
      while (bus.o_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
      chk({tag, "_ready"}, 32'(bus.o_ready), 1);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, 32'(bus.o_valid), 1);
    chk({tag, "_ready_done"}, 32'(bus.o_ready), 0);
    chk({tag, "_acc"}, $signed(bus.o_acc), v.exp_acc);
    chk({tag, "_data"}, $signed(bus.o_data), v.exp_data);
    chk({tag, "_sat"}, 32'(bus.o_sat), 32'(v.exp_sat));
    if (settle) begin
      bus.i_valid = v.hold;
      bus.i_data  = NB_IN'(300);
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      chk({tag, "_valid_after"}, 32'(bus.o_valid), 0);
      chk({tag, "_ready_after"}, 32'(bus.o_ready), 1);
      chk({tag, "_data_held"}, $signed(bus.o_data), v.exp_data);
    end else begin
      bus.i_valid = 1'b0;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t tab[10];
    vec_t v;

    tab[0] = mkv(64, 64, 0, 1'b0, 512, 128, 1'b0);
    tab[1] = mkv(6, 0, 0, 1'b0, 6, 2, 1'b0);
    tab[2] = mkv(5, 0, 0, 1'b0, 5, 1, 1'b0);
    tab[3] = mkv(-6, 0, 0, 1'b0, -6, -1, 1'b0);
    tab[4] = mkv(2047, 2047, 0, 1'b0, 16376, 511, 1'b1);
    tab[5] = mkv(-2048, -2048, 0, 1'b0, -16384, -512, 1'b1);
    tab[6] = mkv(64, 64, 3, 1'b1, 512, 128, 1'b0);
    tab[7] = mkv(-2, 0, 1, 1'b1, -2, 0, 1'b0);
    tab[8] = mkv(2044, 0, 0, 1'b0, 2044, 511, 1'b0);
    tab[9] = mkv(2046, 0, 2, 1'b1, 2046, 511, 1'b1);

    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    #12;
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_data", $signed(bus.o_data), 0);
    chk("rst_acc", $signed(bus.o_acc), 0);
    chk("rst_sat", 32'(bus.o_sat), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.o_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_frame(tab[i], 1'b1, $sformatf("vec%0d", i));

    // Reset part-way through a frame: nothing emitted, next frame starts clean.
    pulses.delete();
    for (int i = 0; i < 5; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = NB_IN'(64);
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.o_valid), 0);
    chk("midrst_data", $signed(bus.o_data), 0);
    chk("midrst_acc", $signed(bus.o_acc), 0);
    chk("midrst_sat", 32'(bus.o_sat), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(tab[0], 1'b1, "after_rst");
    chk("midrst_pulses", pulses.size(), 1);

    // Reset asserted while o_valid is high drops it without a clock edge.
    run_frame(tab[0], 1'b0, "done_rst");
    #1 rst = 1'b1;
    #1;
    chk("done_rst_valid", 32'(bus.o_valid), 0);
    chk("done_rst_ready", 32'(bus.o_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back frames with input held valid through DONE.
    pulses.delete();
    run_frame(mkv(64, 64, 0, 1'b0, 512, 128, 1'b0), 1'b0, "b2b1");
    run_frame(mkv(-64, -64, 0, 1'b1, -512, -128, 1'b0), 1'b1, "b2b2");
    chk("b2b_pulses", pulses.size(), 2);
    chk("b2b_spacing", (pulses.size() == 2) ? (pulses[1] - pulses[0]) : -1, N + 1);

    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < N; i++) begin
        case (f % 3)
          0: v.smp[i] = NB_IN'($urandom_range(4095));
          1: v.smp[i] = NB_IN'(int'($urandom_range(2047, 1400)));
          default: v.smp[i] = NB_IN'(-int'($urandom_range(2048, 1400)));
        endcase
      end
      v.gap  = $urandom_range(3);
      v.hold = 1'($urandom_range(1));
      v = model(v);
      run_frame(v, 1'($urandom_range(1)), $sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
